// File: rtl/clock_disp_pkg.sv
// Shared types and constants for the clock display/time-set controller.
// The state encoding and the BCD wrap limits live here so that both the controller and the bench agree on them.
package clock_disp_pkg;

    typedef enum logic [1:0] {
        SHOW_HM   = 2'd0,
        SHOW_MS   = 2'd1,
        EDIT_HOUR = 2'd2,
        EDIT_MIN  = 2'd3
    } state_t;

    localparam logic [3:0] BLANK_CODE_DEFAULT = 4'hF;
    localparam logic [7:0] HOUR_MAX = 8'h23;
    localparam logic [7:0] MIN_MAX  = 8'h59;

    function automatic logic isEdit(input state_t s);
        return (s == EDIT_HOUR) || (s == EDIT_MIN);
    endfunction

endpackage

// File: rtl/bcd2_wrap_inc.sv
// Combinational two-digit BCD incrementer.
// When the input equals limit_i, the output wraps to 00.
module bcd2_wrap_inc (
    input  logic [7:0] value_i,
    input  logic [7:0] limit_i,
    output logic [7:0] next_o
);

    always_comb begin
        next_o = 8'h00;
        if (value_i == limit_i) begin
            next_o = 8'h00;
        end else if (value_i[3:0] == 4'd9) begin
            next_o = {value_i[7:4] + 4'd1, 4'd0};
        end else begin
            next_o = {value_i[7:4], value_i[3:0] + 4'd1};
        end
    end

endmodule

// File: rtl/clock_disp_ctrl.sv
// Digit selection, hour/minute edit FSM and LOAD strobe for the 24-hour clock.
// Build option: define CLOCK_DISP_BLINK_EN to blink the field being edited. When it is left undefined, the edited field is never blanked.
module clock_disp_ctrl
    import clock_disp_pkg::*;
#(
    parameter int         BLINK_HALF = 500,
    parameter logic [3:0] BLANK_CODE = BLANK_CODE_DEFAULT
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       ENABLE_kHz,
    input  logic       BTN_MODE,
    input  logic       BTN_SET,
    input  logic       BTN_UP,
    input  logic [3:0] H10,
    input  logic [3:0] H1,
    input  logic [3:0] M10,
    input  logic [3:0] M1,
    input  logic [3:0] S10,
    input  logic [3:0] S1,
    output logic [3:0] L1,
    output logic [3:0] L2,
    output logic [3:0] L3,
    output logic [3:0] L4,
    output logic       LOAD,
    output logic [3:0] SET_H10,
    output logic [3:0] SET_H1,
    output logic [3:0] SET_M10,
    output logic [3:0] SET_M1,
    output logic       EDITING
);

    state_t      state_q;
    logic        modePrev_q, setPrev_q, upPrev_q;
    logic [7:0]  setHour_q, setMin_q;
    logic        load_q, editing_q;
    logic [15:0] dispDigits_q;
    logic [7:0]  hourNext, minNext;
    logic        setEdge, modeEdge, upEdge;
    logic        pairBlank;

    // SET takes priority over MODE, and MODE over UP. Any lower-priority edge in the same cycle is dropped.
    assign setEdge  = BTN_SET & ~setPrev_q;
    assign modeEdge = BTN_MODE & ~modePrev_q & ~setEdge;
    assign upEdge   = BTN_UP & ~upPrev_q & ~setEdge & ~modeEdge;

    bcd2_wrap_inc u_hourInc (.value_i(setHour_q), .limit_i(HOUR_MAX), .next_o(hourNext));
    bcd2_wrap_inc u_minInc  (.value_i(setMin_q),  .limit_i(MIN_MAX),  .next_o(minNext));

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q    <= SHOW_HM;
            modePrev_q <= 1'b0;
            setPrev_q  <= 1'b0;
            upPrev_q   <= 1'b0;
            setHour_q  <= 8'h00;
            setMin_q   <= 8'h00;
            load_q     <= 1'b0;
        end else begin
            modePrev_q <= BTN_MODE;
            setPrev_q  <= BTN_SET;
            upPrev_q   <= BTN_UP;
            load_q     <= 1'b0;
            case (state_q)
                SHOW_HM, SHOW_MS: begin
                    if (setEdge) begin
                        state_q   <= EDIT_HOUR;
                        setHour_q <= {H10, H1};
                        setMin_q  <= {M10, M1};
                    end else if (modeEdge) begin
                        state_q <= (state_q == SHOW_HM) ? SHOW_MS : SHOW_HM;
                    end
                end
                EDIT_HOUR: begin
                    if (setEdge)       state_q   <= EDIT_MIN;
                    else if (modeEdge) state_q   <= SHOW_HM;
                    else if (upEdge)   setHour_q <= hourNext;
                end
                EDIT_MIN: begin
                    if (setEdge) begin
                        state_q <= SHOW_HM;
                        load_q  <= 1'b1;
                    end else if (modeEdge) begin
                        state_q <= SHOW_HM;
                    end else if (upEdge) begin
                        setMin_q <= minNext;
                    end
                end
                default: state_q <= SHOW_HM;
            endcase
        end
    end

`ifdef CLOCK_DISP_BLINK_EN
    localparam int CNT_W = (BLINK_HALF > 1) ? $clog2(2 * BLINK_HALF) : 1;
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BLINK_HALF);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(2 * BLINK_HALF - 1);

    logic [CNT_W-1:0] blinkCnt_q, blinkCnt_d;
    logic             blinkClear;

    // The phase restarts visible whenever a field is entered or bumped, so the user sees the new value at once.
    assign blinkClear = (setEdge & (state_q != EDIT_MIN)) | (upEdge & isEdit(state_q));

    always_comb begin
        blinkCnt_d = blinkCnt_q;
        if (blinkClear) begin
            blinkCnt_d = '0;
        end else if (ENABLE_kHz) begin
            blinkCnt_d = (blinkCnt_q == CNT_LAST) ? '0 : blinkCnt_q + 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) blinkCnt_q <= '0;
        else       blinkCnt_q <= blinkCnt_d;
    end

    assign pairBlank = (blinkCnt_q >= CNT_HALF);
`else
    logic unusedNoBlink;
    assign unusedNoBlink = ENABLE_kHz ^ BLINK_HALF[0];
    assign pairBlank     = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            dispDigits_q <= 16'h0000;
            editing_q    <= 1'b0;
        end else begin
            editing_q <= isEdit(state_q);
            case (state_q)
                SHOW_HM:   dispDigits_q <= {H10, H1, M10, M1};
                SHOW_MS:   dispDigits_q <= {M10, M1, S10, S1};
                EDIT_HOUR: dispDigits_q <= {pairBlank ? {BLANK_CODE, BLANK_CODE} : setHour_q, setMin_q};
                EDIT_MIN:  dispDigits_q <= {setHour_q, pairBlank ? {BLANK_CODE, BLANK_CODE} : setMin_q};
                default:   dispDigits_q <= 16'h0000;
            endcase
        end
    end

    assign L4      = dispDigits_q[15:12];
    assign L3      = dispDigits_q[11:8];
    assign L2      = dispDigits_q[7:4];
    assign L1      = dispDigits_q[3:0];
    assign LOAD    = load_q;
    assign EDITING = editing_q;
    assign SET_H10 = setHour_q[7:4];
    assign SET_H1  = setHour_q[3:0];
    assign SET_M10 = setMin_q[7:4];
    assign SET_M1  = setMin_q[3:0];

endmodule
